// File: rtl/simon_stream_if.sv
// simon_stream_if: word-serial bus front end for a SIMON 128/256 cipher core.
//
// Collects W-bit bus words into a 256-bit key and a 128-bit block, then hands
// each to the core with a valid/load handshake. When the core reports a result,
// this block captures it once and streams it back to the bus as W-bit words.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o bus input handshake; in_sel_i picks key (1) or block (0)
//   in_dec_i             decrypt flag, sampled with block word 0 only
//   in_word_i            bus input word; word 0 is least significant
//   out_valid_o/out_ready_i, out_last_o, out_word_o  result word stream
//   new_key_o/load_key_i       key offer to the core, transfer when both high
//   new_data_o/load_data_i     block offer to the core, transfer when both high
//   enc_dec_o, key_o, block_o  mode, assembled key and block to the core
//   done_key_i           core finished key expansion (level)
//   done_data_i          core result valid on out_data_i (level, held until read)
//   read_data_o          one-cycle pulse: out_data_i has been captured
module simon_stream_if #(
  parameter int unsigned N = 64,
  parameter int unsigned M = 4,
  parameter int unsigned W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Bus input side
  input  logic                  in_valid_i,
  input  logic                  in_sel_i,
  input  logic                  in_dec_i,
  input  logic [W-1:0]          in_word_i,
  output logic                  in_ready_o,
  // Bus result side
  output logic                  out_valid_o,
  output logic                  out_last_o,
  output logic [W-1:0]          out_word_o,
  input  logic                  out_ready_i,
  // Core side
  output logic                  new_key_o,
  output logic                  new_data_o,
  output logic                  enc_dec_o,
  output logic [M-1:0][N-1:0]   key_o,
  output logic [1:0][N-1:0]     block_o,
  input  logic                  load_key_i,
  input  logic                  load_data_i,
  input  logic                  done_key_i,
  input  logic                  done_data_i,
  output logic                  read_data_o,
  input  logic [2*N-1:0]        out_data_i
);

  localparam int unsigned KW  = M * N / W;
  localparam int unsigned BW  = 2 * N / W;
  localparam int unsigned KCW = (KW > 1) ? $clog2(KW) : 1;
  localparam int unsigned BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [KCW-1:0] KLast = KCW'(KW - 1);
  localparam logic [BCW-1:0] BLast = BCW'(BW - 1);

  typedef enum logic [1:0] {StIdle, StCap, StSend} res_state_e;

  // Gates in_ready low while in reset and until the first clock after it.
  logic run_q;

  // Key assembler state
  logic [KCW-1:0] kcnt_q, kcnt_d;
  logic [M*N-1:0] key_q, key_d;
  logic           key_full_q, key_full_d;
  logic           new_key_q, new_key_d;
  logic           key_ok_q, key_ok_d;
  logic           kexp_q, kexp_d;

  // Block assembler state
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [2*N-1:0] block_q, block_d;
  logic           blk_full_q, blk_full_d;
  logic           enc_dec_q, enc_dec_d;

  // Result path state
  res_state_e     state_q;
  logic           blk_busy_q;
  logic [2*N-1:0] obuf_q;
  logic [BCW-1:0] ocnt_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic [W-1:0]   out_word_q;
  logic           read_data_q;

  logic           key_space, data_space;
  logic           key_acc, blk_acc;
  logic           key_xfer, data_xfer;
  logic [BCW-1:0] ocnt_nxt;
  logic [W-1:0]   obuf_nxt_word;

  // A block in flight locks the key buffer so the core never sees a key change
  // mid-encryption; the block buffer may refill while the core is busy.
  assign key_space  = !key_full_q && !blk_busy_q;
  assign data_space = !blk_full_q;
  assign in_ready_o = run_q && (in_sel_i ? key_space : data_space);

  assign key_acc = in_valid_i && in_sel_i && in_ready_o;
  assign blk_acc = in_valid_i && !in_sel_i && in_ready_o;

  // A pending new key or a key still expanding holds back the block so it is
  // never encrypted with a stale schedule.
  assign new_data_o = blk_full_q && key_ok_q && !kexp_q && !new_key_q && !blk_busy_q;

  assign key_xfer  = new_key_q && load_key_i;
  assign data_xfer = new_data_o && load_data_i;

  // ---------------------------------------------------------------------------
  // Key assembler next state
  // ---------------------------------------------------------------------------
  always_comb begin
    kcnt_d     = kcnt_q;
    key_d      = key_q;
    key_full_d = key_full_q;
    new_key_d  = new_key_q;
    key_ok_d   = key_ok_q;
    kexp_d     = kexp_q;

    if (key_acc) begin
      for (int unsigned i = 0; i < KW; i++) begin
        if (kcnt_q == KCW'(i)) begin
          key_d[W*i +: W] = in_word_i;
        end
      end
      if (kcnt_q == KLast) begin
        kcnt_d     = '0;
        key_full_d = 1'b1;
        new_key_d  = 1'b1;
      end else begin
        kcnt_d = kcnt_q + KCW'(1);
      end
    end

    if (key_xfer) begin
      new_key_d  = 1'b0;
      key_full_d = 1'b0;
      key_ok_d   = 1'b0;
      kexp_d     = 1'b1;
    end else if (kexp_q && done_key_i) begin
      kexp_d   = 1'b0;
      key_ok_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Block assembler next state
  // ---------------------------------------------------------------------------
  always_comb begin
    bcnt_d     = bcnt_q;
    block_d    = block_q;
    blk_full_d = blk_full_q;
    enc_dec_d  = enc_dec_q;

    if (blk_acc) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (bcnt_q == BCW'(i)) begin
          block_d[W*i +: W] = in_word_i;
        end
      end
      if (bcnt_q == '0) begin
        enc_dec_d = in_dec_i;
      end
      if (bcnt_q == BLast) begin
        bcnt_d     = '0;
        blk_full_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BCW'(1);
      end
    end

    if (data_xfer) begin
      blk_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      kcnt_q     <= '0;
      key_q      <= '0;
      key_full_q <= 1'b0;
      new_key_q  <= 1'b0;
      key_ok_q   <= 1'b0;
      kexp_q     <= 1'b0;
      bcnt_q     <= '0;
      block_q    <= '0;
      blk_full_q <= 1'b0;
      enc_dec_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      kcnt_q     <= kcnt_d;
      key_q      <= key_d;
      key_full_q <= key_full_d;
      new_key_q  <= new_key_d;
      key_ok_q   <= key_ok_d;
      kexp_q     <= kexp_d;
      bcnt_q     <= bcnt_d;
      block_q    <= block_d;
      blk_full_q <= blk_full_d;
      enc_dec_q  <= enc_dec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result path
  // ---------------------------------------------------------------------------
  assign ocnt_nxt = ocnt_q + BCW'(1);

  always_comb begin
    obuf_nxt_word = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      if (ocnt_nxt == BCW'(i)) begin
        obuf_nxt_word = obuf_q[W*i +: W];
      end
    end
  end

  // IDLE waits for a result of a block we actually issued; CAP latches it and
  // pulses read_data; SEND walks the captured words out, one per out_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      blk_busy_q  <= 1'b0;
      obuf_q      <= '0;
      ocnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_word_q  <= '0;
      read_data_q <= 1'b0;
    end else begin
      read_data_q <= 1'b0;
      if (data_xfer) begin
        blk_busy_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (done_data_i && blk_busy_q) begin
            state_q     <= StCap;
            read_data_q <= 1'b1;
          end
        end
        StCap: begin
          obuf_q      <= out_data_i;
          blk_busy_q  <= 1'b0;
          ocnt_q      <= '0;
          out_valid_q <= 1'b1;
          out_word_q  <= out_data_i[W-1:0];
          out_last_q  <= (BLast == '0);
          state_q     <= StSend;
        end
        StSend: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_word_q  <= '0;
            end else begin
              ocnt_q     <= ocnt_nxt;
              out_word_q <= obuf_nxt_word;
              out_last_q <= (ocnt_nxt == BLast);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign new_key_o   = new_key_q;
  assign enc_dec_o   = enc_dec_q;
  assign key_o       = key_q;
  assign block_o     = block_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_word_o  = out_word_q;
  assign read_data_o = read_data_q;

endmodule
